// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM.
// Owner holds the bus for one timed access; an optional lock chains up to four accesses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no owner; arbitrate between pending requests
// S_ACCESS | owner's latched access drives the RAM for WAIT_CYCLES+1 cycles
// S_DONE   | one-cycle ack/err to the owner; optional locked re-entry
module mem_arbiter #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic                  lock0,
   input  logic                  lock1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_cs,
   output logic                  mem_oe,
   output logic                  mem_we
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] LP_WAIT_LAST  = 3'(WAIT_CYCLES);
   localparam logic [2:0] LP_MAX_GRANTS = 3'd4;

   state_t          r_state;
   logic            r_owner;
   logic            r_prio;
   logic            r_we;
   logic            r_blocked;
   logic [2:0]      r_wait_cnt;
   logic [2:0]      r_grant_cnt;

   logic                  w_any_req;
   logic                  w_pick;
   logic                  w_relock;
   logic                  w_start;
   logic                  w_lat_owner;
   logic                  w_lat_we;
   logic                  w_lat_block;
   logic [ADDR_WIDTH-1:0] w_lat_addr;
   logic [DATA_WIDTH-1:0] w_lat_wdata;

   assign w_any_req   = req0 | req1;
   assign w_pick      = (req0 & req1) ? r_prio : req1;
   assign w_relock    = (r_state == S_DONE)
                        && (r_owner ? (req1 & lock1) : (req0 & lock0))
                        && (r_grant_cnt < LP_MAX_GRANTS);
   assign w_start     = ((r_state == S_IDLE) && w_any_req) || w_relock;
   assign w_lat_owner = (r_state == S_DONE) ? r_owner : w_pick;
   assign w_lat_we    = w_lat_owner ? we1    : we0;
   assign w_lat_addr  = w_lat_owner ? addr1  : addr0;
   assign w_lat_wdata = w_lat_owner ? wdata1 : wdata0;
   // Upper half of the address space has no RAM behind it: time the access, flag err.
   assign w_lat_block = w_lat_addr[ADDR_WIDTH-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_owner     <= 1'b0;
         r_prio      <= 1'b0;
         r_we        <= 1'b0;
         r_blocked   <= 1'b0;
         r_wait_cnt  <= 3'd0;
         r_grant_cnt <= 3'd0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err         <= 1'b0;
         rdata       <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_cs      <= 1'b0;
         mem_oe      <= 1'b0;
         mem_we      <= 1'b0;
      end else if (w_start) begin
         r_state     <= S_ACCESS;
         r_owner     <= w_lat_owner;
         r_we        <= w_lat_we;
         r_blocked   <= w_lat_block;
         r_wait_cnt  <= 3'd0;
         r_grant_cnt <= (r_state == S_DONE) ? r_grant_cnt + 3'd1 : 3'd1;
         if (r_state == S_IDLE)
            r_prio <= ~w_pick;
         gnt0        <= ~w_lat_owner;
         gnt1        <= w_lat_owner;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err         <= 1'b0;
         mem_addr    <= w_lat_addr;
         mem_wdata   <= w_lat_wdata;
         mem_cs      <= ~w_lat_block;
         mem_oe      <= ~w_lat_block & ~w_lat_we;
         mem_we      <= ~w_lat_block & w_lat_we;
      end else begin
         case (r_state)
            S_ACCESS: begin
               if (r_wait_cnt == LP_WAIT_LAST) begin
                  r_state <= S_DONE;
                  mem_cs  <= 1'b0;
                  mem_oe  <= 1'b0;
                  mem_we  <= 1'b0;
                  ack0    <= ~r_owner;
                  ack1    <= r_owner;
                  err     <= r_blocked;
                  rdata   <= (r_we | r_blocked) ? '0 : mem_rdata;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 3'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               gnt0    <= 1'b0;
               gnt1    <= 1'b0;
               ack0    <= 1'b0;
               ack1    <= 1'b0;
               err     <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: address width of requesters and memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..7: extra ACCESS cycles before read data is captured.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1 each: access request from requester 0 (CPU) and requester 1 (DMA/port engine).
REQ-007 SHALL have ports we0/we1, input, 1 each: 1 = write, 0 = read.
REQ-008 SHALL have ports lock0/lock1, input, 1 each: keep ownership for a back-to-back access.
REQ-009 SHALL have ports addr0/addr1, input, ADDR_WIDTH each; and wdata0/wdata1, input, DATA_WIDTH each.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 each: owner of the current access.
REQ-011 SHALL have ports ack0/ack1, output, 1 each: one-cycle completion pulse.
REQ-012 SHALL have ports rdata, output, DATA_WIDTH (shared read return), and err, output, 1 (completion with error).
REQ-013 SHALL have ports mem_addr, output, ADDR_WIDTH; mem_wdata, output, DATA_WIDTH; mem_rdata, input, DATA_WIDTH.
REQ-014 SHALL have ports mem_cs, mem_oe and mem_we, output, 1 each: RAM chip select, output enable and write enable.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-016 IDLE: when any req is high, SHALL select an owner, latch its addr/we/wdata into internal registers and enter ACCESS on the next edge; with no req it SHALL stay in IDLE.
REQ-017 Selection SHALL be round-robin: if only one req is high, that requester wins; if both are high, the requester not granted last wins; after reset requester 0 wins a tie.
REQ-018 ACCESS: gntN of the owner SHALL be high; mem_addr/mem_wdata SHALL drive the latched values; mem_cs = ~latched_addr[ADDR_WIDTH-1]; mem_oe = mem_cs & ~we; mem_we = mem_cs & we.
REQ-019 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, counted by a 3-bit wait counter cleared on entry; on the last ACCESS edge, read data SHALL be registered from mem_rdata.
REQ-020 DONE: the owner's gntN and ackN SHALL be high for exactly one cycle; rdata SHALL hold the captured data (0 for writes) until the next DONE; mem_cs/oe/we SHALL be 0.
REQ-021 Latency SHALL be: req sampled at edge k, ack high in cycle k+WAIT_CYCLES+2.
REQ-022 A requester SHALL hold req, we, addr and wdata stable until ack; the block SHALL ignore changes after latching.
REQ-023 From DONE, if the owner's lock and req are both high, the block SHALL latch new inputs and re-enter ACCESS for the same owner, bypassing arbitration; otherwise it SHALL go to IDLE.
REQ-024 Locked back-to-back accesses SHALL be limited to 4 consecutive grants, after which the block SHALL return to IDLE so the other requester is arbitrated.
REQ-025 If the latched address has its MSB set, the block SHALL keep mem_cs/oe/we at 0, still time the full ACCESS, and in DONE assert err with ack and rdata = 0.
REQ-026 gnt0 and gnt1 SHALL never be high simultaneously; in IDLE both SHALL be 0.
REQ-027 A req deasserted before it is latched SHALL be treated as never made.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, wait counter 0, tie pointer to favour requester 0, and drive gnt*, ack*, err, mem_cs, mem_oe, mem_we, mem_addr, mem_wdata and rdata to 0.
REQ-029 Reset asserted mid-ACCESS SHALL abort the access with no ack; the first edge after release SHALL behave as IDLE.

Verification
REQ-030 Single read, WAIT_CYCLES=1: req0=1, we0=0, addr0=0x0012, mem_rdata=0xA5 -> mem_cs=mem_oe=1 for 2 cycles; ack0 at k+3; rdata=0xA5; err=0.
REQ-031 Simultaneous req0 and req1 after reset -> requester 0 is served first, then requester 1; no overlap of gnt0 and gnt1.
REQ-032 Both requesters held continuously -> grants alternate 0,1,0,1.
REQ-033 lock1=1 with req1 held and req0 high -> 4 consecutive grants to requester 1, then requester 0 is granted.
REQ-034 Write to addr1=0x8001 -> mem_cs=mem_we=0 throughout; ack1 and err high in the same cycle; rdata=0x00.
REQ-035 Reset pulsed in the second ACCESS cycle -> all outputs 0 at once; no ack; a following req0 completes normally.
